// File: rtl/tick_seq_pkg.sv
// tick_sequencer shared types and default sizing.
// Build option: TICK_SEQUENCER_WATCHDOG_EN enables the RUN watchdog.
package tick_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam int PHASES_DEF  = 4;
  localparam int TIMEOUT_DEF = 8000;
  localparam int WBITS_DEF   = 13;

endpackage

// File: rtl/tick_sequencer_watchdog.sv
// Counts RUN cycles since the last tick and flags expiry at TIMEOUT.
// Only instantiated when TICK_SEQUENCER_WATCHDOG_EN is defined.
module tick_watchdog
  import tick_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int WBITS   = WBITS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [WBITS-1:0] LIM = WBITS'(TIMEOUT);

  logic [WBITS-1:0] r_cnt;

  // Saturates at LIM so expire stays up until the FSM leaves RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || clear) begin
      r_cnt <= '0;
    end else if (r_cnt != LIM) begin
      r_cnt <= r_cnt + WBITS'(1);
    end
  end

  assign expire = (r_cnt == LIM);

endmodule

// File: rtl/tick_sequencer.sv
// Tick-driven phase sequencer: IDLE / RUN / FAULT.
// Define TICK_SEQUENCER_WATCHDOG_EN to add the tick-timeout watchdog.
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int PHASES  = PHASES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int WBITS   = WBITS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        tick,
  output logic [$clog2(PHASES)-1:0]   phase,
  output logic                        done,
  output logic                        busy,
  output logic                        fault
);

  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

  if (PHASES < 2 || PHASES > 16 ||
      TIMEOUT >= (1 << WBITS)) begin : g_bad_cfg
    $error("tick_sequencer: bad parameters");
  end

  state_t          r_state;
  state_t          w_state_nx;
  logic [PW-1:0]   r_phase;
  logic [PW-1:0]   w_phase_nx;
  logic            r_done;
  logic            w_done_nx;
  logic            r_busy;
  logic            r_fault;
  logic            r_tick_q;
  logic            w_expire;
  logic            w_in_run;

  assign w_in_run = (r_state == S_RUN);

`ifdef TICK_SEQUENCER_WATCHDOG_EN
  tick_watchdog #(
    .TIMEOUT (TIMEOUT),
    .WBITS   (WBITS)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (tick),
    .run     (w_in_run),
    .expire  (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_done_nx  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_phase_nx = '0;
        if (en && tick) w_state_nx = S_RUN;
      end
      S_RUN: begin
        // en drop beats a back-to-back tick, which beats a timeout.
        if (!en) begin
          w_state_nx = S_IDLE;
          w_phase_nx = '0;
        end else if (tick && r_tick_q) begin
          w_state_nx = S_FAULT;
        end else if (w_expire) begin
          w_state_nx = S_FAULT;
        end else if (tick) begin
          if (r_phase == LAST) begin
            w_phase_nx = '0;
            w_done_nx  = 1'b1;
          end else begin
            w_phase_nx = r_phase + PW'(1);
          end
        end
      end
      S_FAULT: begin
        if (!en) begin
          w_state_nx = S_IDLE;
          w_phase_nx = '0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_phase_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_fault  <= 1'b0;
      r_tick_q <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_phase  <= w_phase_nx;
      r_done   <= w_done_nx;
      r_busy   <= (w_state_nx == S_RUN);
      r_fault  <= (w_state_nx == S_FAULT);
      r_tick_q <= tick;
    end
  end

  assign phase = r_phase;
  assign done  = r_done;
  assign busy  = r_busy;
  assign fault = r_fault;

`ifdef FORMAL
  a_live: assert property (
    @(posedge clk) disable iff (!rst || !en)
    s_eventually done
  );
`endif

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer (PHASES=4 and PHASES=3).
// Honours TICK_SEQUENCER_WATCHDOG_EN for the timeout scenario.
module tb_tick_sequencer;
  import tick_seq_pkg::*;

  localparam int TO = TIMEOUT_DEF;
`ifdef TICK_SEQUENCER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       en   = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] ph4, ph3;
  logic       dn4, dn3, bz4, bz3, ft4, ft3;

  always #5 clk = ~clk;

  tick_sequencer u4 (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .phase(ph4), .done(dn4), .busy(bz4), .fault(ft4)
  );

  tick_sequencer #(.PHASES(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .phase(ph3), .done(dn3), .busy(bz3), .fault(ft3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Model: 0=idle 1=running 2=faulted, per instance.
  int np[2]      = '{4, 3};
  int m_mode[2]  = '{0, 0};
  int m_ph[2]    = '{0, 0};
  int m_dn[2]    = '{0, 0};
  int m_quiet[2] = '{0, 0};
  bit m_prev     = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_mode[d] = 0; m_ph[d] = 0;
        m_dn[d] = 0; m_quiet[d] = 0;
      end
      m_prev = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_dn[d] = 0;
        if (m_mode[d] == 0) begin
          m_ph[d] = 0;
          if (en && tick) begin
            m_mode[d] = 1; m_quiet[d] = 0;
          end
        end else if (m_mode[d] == 1) begin
          if (!en) begin
            m_mode[d] = 0; m_ph[d] = 0;
          end else if (tick && m_prev) begin
            m_mode[d] = 2;
          end else if (WD && m_quiet[d] >= TO) begin
            m_mode[d] = 2;
          end else if (tick) begin
            m_ph[d] = (m_ph[d] + 1) % np[d];
            m_dn[d] = (m_ph[d] == 0) ? 1 : 0;
            m_quiet[d] = 0;
          end else begin
            m_quiet[d]++;
          end
        end else if (!en) begin
          m_mode[d] = 0; m_ph[d] = 0;
        end
      end
      m_prev = tick;
    end
  end

  function automatic logic [31:0] mexp(int d);
    return m_ph[d] * 8 + m_dn[d] * 4 +
           (m_mode[d] == 1 ? 2 : 0) +
           (m_mode[d] == 2 ? 1 : 0);
  endfunction

  int dcnt4 = 0, dcnt3 = 0;
  bit pd4 = 0, pd3 = 0, saw3 = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("u4_cycle", {28'd0, ph4, dn4, bz4, ft4}, mexp(0));
      check("u3_cycle", {28'd0, ph3, dn3, bz3, ft3}, mexp(1));
      check("u4_done_rule",
            {31'd0, dn4 & (pd4 | ~bz4)}, 32'd0);
      check("u3_done_rule",
            {31'd0, dn3 & (pd3 | ~bz3)}, 32'd0);
      if (dn4) dcnt4++;
      if (dn3) dcnt3++;
      if (ph3 == 2'd3) saw3 = 1'b1;
    end
    pd4 = dn4;
    pd3 = dn3;
  end

  task automatic cyc(logic e, logic t);
    en = e;
    tick = t;
    @(negedge clk);
    #1;
  endtask

  task automatic tick_gap(int n);
    cyc(1'b1, 1'b1);
    repeat (n - 1) cyc(1'b1, 1'b0);
  endtask

  int dsave;

  initial begin
    repeat (3) cyc(1'b0, 1'b0);
    check("reset_outs", {ph4, dn4, bz4, ft4}, 0);
    rst = 1'b1;
    repeat (3) cyc(1'b1, 1'b0);
    check("idle_no_tick", bz4, 0);

    cyc(1'b1, 1'b1);
    check("align_busy", bz4, 1);
    check("align_phase", ph4, 0);
    repeat (7500) cyc(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1);
      check("seq_phase", ph4, (k + 1) % 4);
      repeat (7500) cyc(1'b1, 1'b0);
    end
    check("done_once_per_4", dcnt4, 1);

    repeat (3) tick_gap(4);
    check("p3_phase", ph3, 1);
    check("p3_done_cnt", dcnt3, 2);
    check("p3_never_3", saw3, 0);
    check("p4_after7", ph4, 3);

    repeat (2) tick_gap(4);
    check("pre_pair_ph", ph4, 1);
    cyc(1'b1, 1'b1);
    check("pair_first", ph4, 2);
    cyc(1'b1, 1'b1);
    check("pair_fault", ft4, 1);
    check("pair_busy", bz4, 0);
    check("pair_phase", ph4, 2);
    repeat (5) cyc(1'b1, 1'b0);
    check("fault_sticky", {ph4, ft4}, 3'b101);
    cyc(1'b0, 1'b0);
    check("fault_exit", {ph4, dn4, bz4, ft4}, 0);

    repeat (2) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    repeat (3) tick_gap(3);
    check("wrap_pre_ph", ph4, 3);
    dsave = dcnt4;
    cyc(1'b0, 1'b1);
    check("en_drop_wrap", {ph4, dn4, bz4, ft4}, 0);
    cyc(1'b0, 1'b0);
    check("en_drop_nodone", dcnt4, dsave);

    cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    repeat (3) tick_gap(3);
    check("rst_pre_ph", ph4, 3);
    #2 rst = 1'b0;
    #1 check("async_rst", {ph4, dn4, bz4, ft4}, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (4) cyc(1'b1, 1'b0);
    check("post_rst_idle", {ph4, bz4}, 0);

    cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (TO) cyc(1'b1, 1'b0);
    check("wd_before", {bz4, ft4}, 2'b10);
    cyc(1'b1, 1'b0);
    if (WD) begin
      check("wd_fault", {bz4, ft4}, 2'b01);
    end else begin
      repeat (1000) cyc(1'b1, 1'b0);
      check("no_wd_run", {bz4, ft4}, 2'b10);
    end
    cyc(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
